// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS-32 core with one shared, stallable memory port
// Optional bne/ori support is enabled by defining MIPS_MC_EXT_OPS_EN.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [4:0]  DBG_REG    = 5'd2,
   parameter int          TEST_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  Reset,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  mem_re,
   output logic                  mem_we,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ready,
   output logic                  illegal,
   output logic [TEST_WIDTH-1:0] test_value
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
      S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] alu_out_q, alu_out_d;
   logic [31:0] mdr_q, mdr_d;
   logic        illegal_q, illegal_d;
   logic        mem_re_q, mem_re_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        branch_taken;

   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [5:0]  funct;
   logic [31:0] sext_imm;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      a_d          = a_q;
      b_d          = b_q;
      alu_out_d    = alu_out_q;
      mdr_d        = mdr_q;
      rf_we        = 1'b0;
      rf_waddr     = rt;
      rf_wdata     = alu_out_q;
      branch_taken = (a_q == b_q);

      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + 32'd4;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d       = regs_q[rs];
            b_d       = regs_q[rt];
            alu_out_d = pc_q + (sext_imm << 2);
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE: begin
                  case (funct)
                     FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = S_EXEC;
                     default:                               state_d = S_HALT;
                  endcase
               end
               OP_BEQ:  state_d = S_BRANCH;
               OP_ADDI: state_d = S_ADDIEX;
               OP_J:    state_d = S_JUMP;
`ifdef MIPS_MC_EXT_OPS_EN
               OP_BNE:  state_d = S_BRANCH;
               OP_ORI:  state_d = S_ADDIEX;
`endif
               default: state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            alu_out_d = a_q + sext_imm;
            state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            if (mem_ready) begin
               mdr_d   = mem_rdata;
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            rf_we    = 1'b1;
            rf_wdata = mdr_q;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            case (funct)
               FN_SUB:  alu_out_d = a_q - b_q;
               FN_AND:  alu_out_d = a_q & b_q;
               FN_OR:   alu_out_d = a_q | b_q;
               FN_SLT:  alu_out_d = {31'b0, ($signed(a_q) < $signed(b_q))};
               default: alu_out_d = a_q + b_q;
            endcase
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            alu_out_d = a_q + sext_imm;
`ifdef MIPS_MC_EXT_OPS_EN
            if (opcode == OP_ORI) alu_out_d = a_q | {16'b0, ir_q[15:0]};
`endif
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            rf_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
`ifdef MIPS_MC_EXT_OPS_EN
            if (opcode == OP_BNE) branch_taken = (a_q != b_q);
`endif
            if (branch_taken) pc_d = alu_out_q;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            // pc_q already holds PC+4, whose top nibble selects the jump region
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase

      regs_d = regs_q;
      if (rf_we && (rf_waddr != 5'd0)) regs_d[rf_waddr] = rf_wdata;

      illegal_d = illegal_q | (state_d == S_HALT);

      // Memory outputs are registered from the next state so they line up with it
      mem_re_d    = (state_d == S_FETCH) || (state_d == S_MEMRD);
      mem_we_d    = (state_d == S_MEMWR);
      mem_wdata_d = (state_d == S_MEMWR) ? b_d : 32'd0;
      case (state_d)
         S_FETCH:          mem_addr_d = pc_d;
         S_MEMRD, S_MEMWR: mem_addr_d = alu_out_d;
         default:          mem_addr_d = 32'd0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         alu_out_q   <= '0;
         mdr_q       <= '0;
         illegal_q   <= 1'b0;
         mem_re_q    <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= RESET_PC;
         mem_wdata_q <= '0;
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         alu_out_q   <= alu_out_d;
         mdr_q       <= mdr_d;
         illegal_q   <= illegal_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         regs_q      <= regs_d;
      end
   end

   assign mem_re     = mem_re_q & ~Reset;
   assign mem_we     = mem_we_q & ~Reset;
   assign mem_addr   = Reset ? 32'd0 : mem_addr_q;
   assign mem_wdata  = Reset ? 32'd0 : mem_wdata_q;
   assign illegal    = illegal_q;
   assign test_value = regs_q[DBG_REG][TEST_WIDTH-1:0];

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - directed self-checking bench for mips_multicycle_core
module tb_mips_multicycle_core;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        illegal;
   logic [15:0] test_value;

   mips_multicycle_core dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .illegal    (illegal),
      .test_value (test_value)
   );

   always #5 CLK = ~CLK;

   logic [31:0]   prog [1024];
   logic [31:0]   dmem [1024];
   logic [1023:0] dvalid;
   logic [31:0]   wr_addr;
   logic [31:0]   wr_data;
   logic [31:0]   wr_cnt;

   // Garbage on the bus while not ready exposes any early capture
   assign mem_rdata = !mem_ready ? 32'hDEAD_BEEF :
                      (dvalid[mem_addr[11:2]] ? dmem[mem_addr[11:2]] : prog[mem_addr[11:2]]);

   always @(posedge CLK) begin
      if (Reset) begin
         dvalid <= '0;
         wr_cnt <= '0;
      end else if (mem_we && mem_ready) begin
         dmem[mem_addr[11:2]]   <= mem_wdata;
         dvalid[mem_addr[11:2]] <= 1'b1;
         wr_addr                <= mem_addr;
         wr_data                <= mem_wdata;
         wr_cnt                 <= wr_cnt + 32'd1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   task automatic clear_prog;
      for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
   endtask

   task automatic do_reset;
      Reset     = 1'b1;
      mem_ready = 1'b1;
      tick(2);
      Reset = 1'b0;
      #1;
   endtask

   task automatic wait_fetch(input logic [31:0] addr, output int cyc);
      cyc = 0;
      do begin
         tick(1);
         cyc++;
      end while (!(mem_re && mem_addr == addr) && cyc < 60);
   endtask

   int cyc;
   int held;
   int stall;
   logic [15:0] alu_exp [6];

   initial begin
      Reset     = 1'b1;
      mem_ready = 1'b1;
      clear_prog();

      // Reset state and the first instruction sequence
      prog[0] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
      prog[1] = enc_i(6'h08, 5'd0, 5'd3, 16'd7);
      prog[2] = enc_r(5'd2, 5'd3, 5'd2, 6'h20);
      tick(2);
      check("rst_mem_re", {31'b0, mem_re}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_illegal", {31'b0, illegal}, 32'd0);
      check("rst_test_value", {16'b0, test_value}, 32'd0);
      Reset = 1'b0;
      #1;
      check("post_rst_re", {31'b0, mem_re}, 32'd1);
      check("post_rst_addr", mem_addr, 32'd0);
      tick(11);
      check("addi_c11", {16'b0, test_value}, 32'd5);
      tick(1);
      check("add_c12", {16'b0, test_value}, 32'd12);
      check("add_illegal", {31'b0, illegal}, 32'd0);

      // Store then load through the shared port
      clear_prog();
      prog[0] = enc_i(6'h08, 5'd0, 5'd4, 16'h0040);
      prog[1] = enc_i(6'h2B, 5'd4, 5'd4, 16'h0000);
      prog[2] = enc_i(6'h23, 5'd4, 5'd2, 16'h0000);
      prog[3] = 32'h0800_0003;
      do_reset();
      wait_fetch(32'h8, cyc);
      check("addi_sw_cycles", cyc, 32'd8);
      check("sw_count", wr_cnt, 32'd1);
      check("sw_addr", wr_addr, 32'h40);
      check("sw_data", wr_data, 32'h40);
      wait_fetch(32'hC, cyc);
      check("lw_cycles", cyc, 32'd5);
      check("lw_value", {16'b0, test_value}, 32'h40);

      // Load with three wait cycles in the read state
      clear_prog();
      prog[0]  = enc_i(6'h08, 5'd0, 5'd4, 16'h0040);
      prog[1]  = enc_i(6'h23, 5'd4, 5'd2, 16'h0000);
      prog[2]  = 32'h0800_0002;
      prog[16] = 32'h1234_ABCD;
      do_reset();
      wait_fetch(32'h4, cyc);
      check("stall_addi_cycles", cyc, 32'd4);
      cyc   = 0;
      held  = 0;
      stall = 3;
      do begin
         mem_ready = 1'b1;
         if (mem_re && mem_addr == 32'h40) begin
            held++;
            if (stall > 0) begin
               mem_ready = 1'b0;
               stall--;
            end
         end
         tick(1);
         cyc++;
      end while (!(mem_re && mem_addr == 32'h8) && cyc < 60);
      mem_ready = 1'b1;
      check("stall_lw_cycles", cyc, 32'd8);
      check("stall_held", held, 32'd4);
      check("stall_lw_value", {16'b0, test_value}, 32'hABCD);

      // R-type ALU operations and writes to $0
      clear_prog();
      prog[0] = enc_i(6'h08, 5'd0, 5'd3, 16'hFFFD);
      prog[1] = enc_i(6'h08, 5'd0, 5'd4, 16'd5);
      prog[2] = enc_r(5'd3, 5'd4, 5'd2, 6'h22);
      prog[3] = enc_r(5'd3, 5'd4, 5'd2, 6'h24);
      prog[4] = enc_r(5'd3, 5'd4, 5'd2, 6'h25);
      prog[5] = enc_r(5'd3, 5'd4, 5'd2, 6'h2A);
      prog[6] = enc_r(5'd4, 5'd3, 5'd2, 6'h2A);
      prog[7] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      prog[8] = enc_r(5'd0, 5'd4, 5'd2, 6'h20);
      alu_exp = '{16'hFFF8, 16'h0005, 16'hFFFD, 16'h0001, 16'h0000, 16'h0000};
      do_reset();
      wait_fetch(32'h8, cyc);
      for (int i = 0; i < 6; i++) begin
         wait_fetch(32'hC + 32'(4 * i), cyc);
         check($sformatf("alu_val_%0d", i), {16'b0, test_value}, {16'b0, alu_exp[i]});
         check($sformatf("alu_cyc_%0d", i), cyc, 32'd4);
      end
      wait_fetch(32'h24, cyc);
      check("add_zero_reg", {16'b0, test_value}, 32'd5);

      // beq back to itself, then an absolute jump
      clear_prog();
      prog[0] = enc_i(6'h08, 5'd0, 5'd5, 16'd1);
      prog[1] = enc_i(6'h08, 5'd0, 5'd6, 16'd2);
      prog[2] = 32'h1000_FFFF;
      do_reset();
      wait_fetch(32'h8, cyc);
      check("beq_reach", cyc, 32'd8);
      wait_fetch(32'h8, cyc);
      check("beq_loop_1", cyc, 32'd3);
      wait_fetch(32'h8, cyc);
      check("beq_loop_2", cyc, 32'd3);

      clear_prog();
      prog[0] = 32'h0800_0100;
      do_reset();
      wait_fetch(32'h400, cyc);
      check("j_target_cycles", cyc, 32'd3);

      // Illegal opcode halts; a one-cycle reset recovers
      clear_prog();
      prog[0] = 32'hFC00_0000;
      do_reset();
      tick(2);
      check("halt_illegal", {31'b0, illegal}, 32'd1);
      check("halt_re", {31'b0, mem_re}, 32'd0);
      tick(5);
      check("halt_re_later", {31'b0, mem_re}, 32'd0);
      check("halt_sticky", {31'b0, illegal}, 32'd1);
      Reset = 1'b1;
      #1;
      check("halt_rst_re", {31'b0, mem_re}, 32'd0);
      tick(1);
      Reset = 1'b0;
      #1;
      check("recover_illegal", {31'b0, illegal}, 32'd0);
      check("recover_re", {31'b0, mem_re}, 32'd1);
      check("recover_addr", mem_addr, 32'd0);

      // ori: supported only with the extension build
      clear_prog();
      prog[0] = 32'h3402_FFFF;
      prog[1] = enc_r(5'd0, 5'd2, 5'd2, 6'h2A);
      do_reset();
`ifdef MIPS_MC_EXT_OPS_EN
      wait_fetch(32'h4, cyc);
      check("ori_cycles", cyc, 32'd4);
      check("ori_value", {16'b0, test_value}, 32'hFFFF);
      check("ori_illegal", {31'b0, illegal}, 32'd0);
      wait_fetch(32'h8, cyc);
      check("ori_upper_zero", {16'b0, test_value}, 32'd1);
`else
      tick(2);
      check("ori_illegal", {31'b0, illegal}, 32'd1);
      check("ori_halt_re", {31'b0, mem_re}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
